// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for a multi-cycle instruction pipeline. A five-state
// FSM (IDLE, FETCH, INC, RESOLVE, TARGET) steps the PC through fetch, PC+4,
// resolution of jump/branch/halt and an optional branch-target cycle. One
// 32-bit adder is shared: it forms pc+4 in INC and pc4+(offset<<2) in TARGET.
//
// Parameters
//   RESET_PC     PC loaded on reset and on start
//
// Ports
//   clk          clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   start        begin sequencing from RESET_PC (sampled only in IDLE)
//   instr_ready  instruction word at pc is available (sampled only in FETCH)
//   ex_done      execution resolved the current instruction (only in RESOLVE)
//   branch       conditional-branch instruction
//   zero         ALU zero flag
//   jump         unconditional jump
//   halt         stop after the current instruction
//   offset       sign-extended branch immediate (word offset)
//   jump_target  26-bit jump index
//   pc           registered program counter
//   fetch_req    fetch request at pc (high in FETCH)
//   busy         high in every state except IDLE
//   redirect     one-cycle pulse in the cycle a jump/branch target appears on pc
//   instr_count  retired-instruction counter (wraps modulo 2^32)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        instr_ready,
    input  logic        ex_done,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        halt,
    input  logic [31:0] offset,
    input  logic [25:0] jump_target,
    output logic [31:0] pc,
    output logic        fetch_req,
    output logic        busy,
    output logic        redirect,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        INC,
        RESOLVE,
        TARGET
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] offset_q, offset_d;
    logic [31:0] count_q, count_d;
    logic        halt_q, halt_d;
    logic        redirect_q, redirect_d;

    // Shared adder. Only INC and TARGET consume the sum, so the operand
    // selection keys on TARGET and defaults to the pc+4 form elsewhere.
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;

    always_comb begin
        add_a   = (state_q == TARGET) ? pc4_q : pc_q;
        add_b   = (state_q == TARGET) ? (offset_q << 2) : 32'd4;
        add_sum = add_a + add_b;
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        offset_d   = offset_q;
        count_d    = count_q;
        halt_d     = halt_q;
        redirect_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (instr_ready) begin
                    state_d = INC;
                end
            end

            INC: begin
                pc4_d   = add_sum;
                state_d = RESOLVE;
            end

            RESOLVE: begin
                if (ex_done) begin
                    count_d = count_q + 32'd1;
                    // halt is only valid alongside ex_done; keep it for
                    // the TARGET cycle where the inputs are no longer valid.
                    halt_d  = halt;
                    if (jump) begin
                        pc_d       = {pc4_q[31:28], jump_target, 2'b00};
                        redirect_d = 1'b1;
                        state_d    = halt ? IDLE : FETCH;
                    end else if (branch && zero) begin
                        offset_d = offset;
                        state_d  = TARGET;
                    end else begin
                        pc_d    = pc4_q;
                        state_d = halt ? IDLE : FETCH;
                    end
                end
            end

            TARGET: begin
                pc_d       = add_sum;
                redirect_d = 1'b1;
                state_d    = halt_q ? IDLE : FETCH;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pc4_q      <= 32'd0;
            offset_q   <= 32'd0;
            count_q    <= 32'd0;
            halt_q     <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            offset_q   <= offset_d;
            count_q    <= count_d;
            halt_q     <= halt_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_req   = (state_q == FETCH);
    assign busy        = (state_q != IDLE);
    assign redirect    = redirect_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Scoreboard bench for pc_sequencer. The driver walks the handshake (start,
// instr_ready, ex_done) with random stalls and junk on ignored inputs, and for
// every start/instruction/reset pushes the expected observable outcome: the pc
// and instr_count seen at the next fetch (or on return to IDLE), whether
// redirect is high in that cycle, and the cycle in which it must appear.
// An independent monitor pops an entry whenever the DUT begins a new fetch or
// drops busy, and flags any redirect outside those cycles.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        instr_ready;
    logic        ex_done;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        halt;
    logic [31:0] offset;
    logic [25:0] jump_target;
    logic [31:0] pc;
    logic        fetch_req;
    logic        busy;
    logic        redirect;
    logic [31:0] instr_count;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instr_ready (instr_ready),
        .ex_done     (ex_done),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .halt        (halt),
        .offset      (offset),
        .jump_target (jump_target),
        .pc          (pc),
        .fetch_req   (fetch_req),
        .busy        (busy),
        .redirect    (redirect),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        redir;
        logic        idle;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] pc_m;
    logic [31:0] cnt_m;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic summary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
        summary();
    endtask

    // Random values on data inputs; used wherever the DUT must not look.
    task automatic junk();
        branch      = 1'($urandom_range(0, 1));
        zero        = 1'($urandom_range(0, 1));
        jump        = 1'($urandom_range(0, 1));
        halt        = 1'($urandom_range(0, 1));
        offset      = $urandom;
        jump_target = 26'($urandom);
    endtask

    task automatic do_start(input int idle_cyc);
        int   n;
        exp_t e;
        n = 0;
        while (busy !== 1'b0) begin
            @(negedge clk);
            n++;
            if (n > 20) timeout("idle_wait");
        end
        for (int i = 0; i < idle_cyc; i++) begin
            start       = 1'b0;
            instr_ready = 1'($urandom_range(0, 1));
            ex_done     = 1'($urandom_range(0, 1));
            junk();
            @(negedge clk);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_pc", pc, pc_m);
        end
        instr_ready = 1'b0;
        ex_done     = 1'b0;
        start       = 1'b1;
        pc_m        = RST_PC;
        e.pc    = RST_PC;
        e.cnt   = cnt_m;
        e.redir = 1'b0;
        e.idle  = 1'b0;
        e.cyc   = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_instr(input logic j, input logic b, input logic z, input logic h,
                             input logic [31:0] off, input logic [25:0] jt,
                             input int stall, input int exwait, input bit rst_tgt);
        int          n;
        exp_t        e;
        logic [31:0] pc4;
        n = 0;
        while (fetch_req !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 20) timeout("fetch_wait");
        end
        // Fetch stall: start and ex_done are noise here
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            start       = 1'($urandom_range(0, 1));
            ex_done     = 1'($urandom_range(0, 1));
            junk();
            @(negedge clk);
            chk("stall_fetch_req", {31'd0, fetch_req}, 32'd1);
            chk("stall_pc", pc, pc_m);
        end
        start       = 1'b0;
        ex_done     = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        // PC+4 cycle: an ex_done here must be ignored
        instr_ready = 1'b0;
        ex_done     = 1'b1;
        start       = 1'($urandom_range(0, 1));
        junk();
        @(negedge clk);
        for (int i = 0; i < exwait; i++) begin
            ex_done     = 1'b0;
            instr_ready = 1'($urandom_range(0, 1));
            start       = 1'($urandom_range(0, 1));
            junk();
            @(negedge clk);
        end
        start       = 1'b0;
        instr_ready = 1'b0;
        ex_done     = 1'b1;
        jump        = j;
        branch      = b;
        zero        = z;
        halt        = h;
        offset      = off;
        jump_target = jt;
        pc4   = pc_m + 32'd4;
        cnt_m = cnt_m + 32'd1;
        if (j) begin
            e.pc    = {pc4[31:28], jt, 2'b00};
            e.redir = 1'b1;
            e.cyc   = cyc + 1;
        end else if (b && z) begin
            e.pc    = pc4 + off * 32'd4;
            e.redir = 1'b1;
            e.cyc   = cyc + 2;
        end else begin
            e.pc    = pc4;
            e.redir = 1'b0;
            e.cyc   = cyc + 1;
        end
        e.cnt  = cnt_m;
        e.idle = h;
        if (!rst_tgt) begin
            sbq.push_back(e);
            pc_m = e.pc;
        end
        @(negedge clk);
        ex_done = 1'b0;
        junk();
        if (rst_tgt) begin
            rst     = 1'b1;
            e.pc    = RST_PC;
            e.cnt   = 32'd0;
            e.redir = 1'b0;
            e.idle  = 1'b1;
            e.cyc   = cyc + 1;
            sbq.push_back(e);
            pc_m  = RST_PC;
            cnt_m = 32'd0;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    // Monitor
    initial begin
        logic prev_fetch;
        logic prev_busy;
        logic ev_fetch;
        logic ev_idle;
        exp_t e;
        prev_fetch = 1'b0;
        prev_busy  = 1'b0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            ev_fetch = fetch_req && !prev_fetch;
            ev_idle  = !busy && prev_busy;
            if (ev_fetch || ev_idle) begin
                $display("EVT cyc=%0d pc=%h cnt=%0d redirect=%b idle=%b",
                         cyc, pc, instr_count, redirect, ev_idle);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=pc_%h required=no_event", pc);
                end else begin
                    e = sbq.pop_front();
                    chk("event_kind_idle", {31'd0, ev_idle}, {31'd0, e.idle});
                    chk("pc", pc, e.pc);
                    chk("instr_count", instr_count, e.cnt);
                    chk("redirect", {31'd0, redirect}, {31'd0, e.redir});
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("redirect_stray", {31'd0, redirect}, 32'd0);
            end
            prev_fetch = fetch_req;
            prev_busy  = busy;
        end
    end

    initial begin
        #500000;
        timeout("global_time_limit");
    end

    // Driver
    initial begin
        logic j, b, z, h;
        bit   rt;
        rst         = 1'b1;
        start       = 1'b0;
        instr_ready = 1'b0;
        ex_done     = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        jump        = 1'b0;
        halt        = 1'b0;
        offset      = 32'd0;
        jump_target = 26'd0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_instr_count", instr_count, 32'd0);
        rst    = 1'b0;
        pc_m   = RST_PC;
        cnt_m  = 32'd0;
        mon_en = 1'b1;

        do_start(2);
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        26'h0,   0, 0, 1'b0); // wrap to 0
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        26'h40,  1, 0, 1'b0); // -> 0x100
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        26'h0,   0, 0, 1'b0); // -> 0x104
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        26'h40,  0, 1, 1'b0); // -> 0x100
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 32'h3,        26'h0,   0, 0, 1'b0); // -> 0x110
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        26'h40,  0, 0, 1'b0); // -> 0x100
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 26'h0,   0, 0, 1'b0); // -> 0xFC
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        26'h400, 0, 0, 1'b0); // -> 0x1000
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h5,        26'h40,  0, 0, 1'b0); // jump wins
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 32'h7,        26'h0,   0, 0, 1'b0); // untaken
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        26'h0,   5, 2, 1'b0); // stall, halt
        do_start(3);
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 32'h10,       26'h0,   0, 0, 1'b1); // reset in TARGET
        do_start(1);

        for (int k = 0; k < 60; k++) begin
            j  = 1'($urandom_range(0, 3) == 0);
            b  = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            h  = 1'($urandom_range(0, 7) == 0);
            rt = (b && z && !j && ($urandom_range(0, 5) == 0));
            run_instr(j, b, z, h, $urandom, 26'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rt);
            if (h || rt) do_start(int'($urandom_range(0, 3)));
        end

        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        summary();
    end

endmodule
